// File: rtl/sram_bank_arbiter_pkg.sv
// Shared definitions for the two-master SRAM bank arbiter.
//   NUM_MASTERS    : number of requesting masters (core data port, debug port)
//   MST_CORE       : index of the core data port master
//   MST_DBG        : index of the debug/AXI port master
//   BANK_BYTES_DEF : default bank size in bytes
package sram_bank_arbiter_pkg;

  localparam int NUM_MASTERS    = 2;
  localparam int MST_CORE       = 0;
  localparam int MST_DBG        = 1;
  localparam int BANK_BYTES_DEF = 8192;

endpackage

// File: rtl/sram_bank_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a single-bit "last granted" pointer.
// Ports:
//   clk_i     : clock
//   rstn_i    : synchronous active-low reset
//   req_i     : per-master request (already qualified by the caller)
//   advance_i : a grant is being taken this cycle, update the pointer
//   gnt_o     : one-hot (or zero) combinational grant
module rr_arb2
  import sram_bank_arbiter_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   advance_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  // last_q holds the index of the master granted most recently; it resets to
  // the debug master so the core port wins the first contested cycle.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = gnt_o[MST_DBG];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Arbitrates two masters onto one single-ported SRAM bank.
// Ports:
//   clk_i, rstn_i          : clock, synchronous active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i : per-master request channel
//   gnt_o                  : per-master combinational grant
//   rvalid_o/rdata_o/err_o : response channel, one cycle after each grant
//   mem_*_o / mem_rdata_i  : bank interface, read data one cycle after enable
module sram_bank_arbiter
  import sram_bank_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BANK_BYTES = BANK_BYTES_DEF
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic [NUM_MASTERS-1:0]                 req_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_MASTERS-1:0]                 we_i,
  input  logic [NUM_MASTERS-1:0][3:0]            be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_MASTERS-1:0]                 gnt_o,
  output logic [NUM_MASTERS-1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic                                   err_o,
  output logic                                   mem_en_o,
  output logic                                   mem_we_o,
  output logic [3:0]                             mem_be_o,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i
);

  localparam logic [31:0] BANK_LIMIT = 32'(BANK_BYTES);

  function automatic logic in_bank(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < BANK_LIMIT;
  endfunction

  // Requests are masked during reset so no grant (and no pointer update)
  // can happen in the reset cycle.
  logic [NUM_MASTERS-1:0] req_q_mask;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   granted;
  logic                   sel;
  logic                   in_range;

  assign req_q_mask = req_i & {NUM_MASTERS{rstn_i}};
  assign granted    = |gnt;
  assign sel        = gnt[MST_DBG];
  assign in_range   = in_bank(addr_i[sel]);

  rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (req_q_mask),
    .advance_i (granted),
    .gnt_o     (gnt)
  );

  assign gnt_o = gnt;

  // Bank steering: address/data always follow the selected master; only the
  // enable is qualified, so out-of-range grants never touch the bank.
  assign mem_en_o    = granted & in_range;
  assign mem_we_o    = we_i[sel];
  assign mem_be_o    = be_i[sel];
  assign mem_addr_o  = addr_i[sel];
  assign mem_wdata_o = wdata_i[sel];

  // Response stage
  logic rvalid_q, rvalid_d;
  logic rid_q, rid_d;
  logic rerr_q, rerr_d;
  logic rwe_q, rwe_d;
  logic resp_vld;

  assign rvalid_d = granted;
  assign rid_d    = sel;
  assign rerr_d   = ~in_range;
  assign rwe_d    = we_i[sel];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rid_q  <= rid_d;
    rerr_q <= rerr_d;
    rwe_q  <= rwe_d;
  end

  // A response still pending when reset rises is suppressed at once, so a
  // grant taken just before reset never surfaces as a response.
  assign resp_vld = rvalid_q & rstn_i;

  always_comb begin
    rvalid_o           = '0;
    rvalid_o[MST_CORE] = resp_vld & ~rid_q;
    rvalid_o[MST_DBG]  = resp_vld & rid_q;
  end

  assign err_o   = resp_vld & rerr_q;
  assign rdata_o = (resp_vld & ~rerr_q & ~rwe_q) ? mem_rdata_i : '0;

endmodule
